instr_fetch_queue: RTL
======================

# instr_fetch_queue

Parametrised fetch buffer between the instruction-memory interface and decode. Holds up to DEPTH {pc, instr} pairs in arrival order, with valid/ready handshakes on both sides so fetch can run ahead of a stalled decode stage. Synchronous flush discards all buffered entries on a redirect (branch/jump/trap). Replaces the single-entry, write-enable-only instruction register with a multi-entry, backpressure-aware queue.

## Interface
- XLEN, 32, width of pc and instruction words
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all entries this cycle
- in_valid  in  1  fetch offers a pair
- in_ready  out  1  queue accepts a pair
- in_pc  in  XLEN  pc of offered instruction
- in_instr  in  XLEN  offered instruction word
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode consumes head
- out_pc  out  XLEN  pc of head entry
- out_instr  out  XLEN  head instruction word
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry circular buffer, write pointer wr_ptr, read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0; occupancy register count.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !flush & (count != DEPTH). No push while full, even if a pop occurs the same cycle (no combinational out_ready → in_ready path).
- out_valid = !flush & (count != 0) (see Configuration for the bypass term).
- out_pc/out_instr = entry at rd_ptr when out_valid, else 0.
- push only: write entry at wr_ptr, wr_ptr+1, count+1.
- pop only: rd_ptr+1, count−1.
- push and pop together (0 < count < DEPTH): both pointers advance, count unchanged.
- flush: highest priority below rst; next cycle wr_ptr = rd_ptr = 0, count = 0. Same-cycle push and pop are suppressed (in_ready = out_valid = 0 during the flush cycle).
- rst: same as flush plus storage cleared to 0. During the rst cycle in_ready = 0, out_valid = 0.
- Reset values: in_ready = 1 (from the first cycle after rst deasserts), out_valid = 0, out_pc = 0, out_instr = 0, count = 0.
- rst or flush asserted mid-stream drops all entries; no partial drain.

## Timing
- Without bypass: a pair pushed in cycle N is visible at the outputs in cycle N+1 (1-cycle latency). With bypass into an empty queue: latency 0.
- Sustained throughput: 1 pair/cycle when 0 < count < DEPTH and both sides are valid/ready.
- At count = DEPTH with out_ready = 1: that cycle pops only; in_ready rises in the next cycle.
- count, pointers and storage are all registered; out_* are a combinational read of storage at rd_ptr (plus the bypass mux).
- flush in cycle N: out_valid = 0 in cycle N; the first post-flush push is accepted in cycle N+1 and appears at the outputs in cycle N+2 (or N+1 with bypass).

## Configuration
- IFQ_BYPASS_EN defined: when count = 0, flush = 0 and in_valid = 1, then out_valid = 1 and out_pc/out_instr = in_pc/in_instr combinationally.
  - If out_ready = 1 the pair passes through without being stored; count stays 0.
  - Otherwise the pair is stored normally and count becomes 1.
- IFQ_BYPASS_EN undefined: no in→out combinational path; out_valid depends only on count; minimum latency is 1 cycle.

## Test plan
- Reset: hold rst 2 cycles with in_valid = 1 → count = 0, out_valid = 0, out_pc = out_instr = 0 during and after; in_ready = 1 the cycle after release.
- Fill/drain: out_ready = 0, push pc 0x00,0x04,0x08,0x0C (DEPTH = 4) → count = 4, in_ready = 0, 5th offer not accepted. Then out_ready = 1 → outputs 0x00..0x0C in order, count 3,2,1,0.
- Wrap-around: 10 push/pop cycles at count = 2 with incrementing pc → output pc sequence strictly in order across pointer wrap; count stays 2.
- Full with pop: count = 4, in_valid = 1, out_ready = 1 → that cycle pops only (count 3); push accepted the next cycle (count stays 3 with continued pop).
- Flush: count = 3, assert flush with in_valid = 1 and out_ready = 1 → out_valid = 0 and in_ready = 0 that cycle; next cycle count = 0; the next push of pc 0x100 is the next output.
- Bypass (IFQ_BYPASS_EN): empty queue, in_valid = 1, pc 0x40, out_ready = 1 → out_pc = 0x40 same cycle, count stays 0. Without the macro: out_valid = 0 that cycle, pc 0x40 appears the next cycle.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Multi-entry {pc, instr} fetch queue with valid/ready handshakes on both sides and synchronous flush.
// Optional macro IFQ_BYPASS_EN: an empty queue forwards the offered pair combinationally to decode.
module instr_fetch_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic empty;
    logic full;
    logic byp;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    always_comb begin
        empty = (count == '0);
        full  = (count == CW'(DEPTH));
`ifdef IFQ_BYPASS_EN
        byp   = empty & in_valid & !flush & !rst;
`else
        byp   = 1'b0;
`endif
        in_ready  = !rst & !flush & !full;
        out_valid = !rst & !flush & (!empty | byp);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        // A bypassed pair that is consumed immediately never touches storage
        wr_en     = push & !(byp & out_ready);
        rd_en     = pop & !empty;

        out_pc    = '0;
        out_instr = '0;
        if (out_valid) begin
            if (byp) begin
                out_pc    = in_pc;
                out_instr = in_instr;
            end else begin
                out_pc    = pc_mem[rd_ptr];
                out_instr = instr_mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[AW'(i)]    <= '0;
                instr_mem[AW'(i)] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                pc_mem[wr_ptr]    <= in_pc;
                instr_mem[wr_ptr] <= in_instr;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
